// File: rtl/main_fsb_if.sv
// Keypad / ALU / display bus of the BCD calculator control FSM.
// slave  : the control FSM (takes keys and ALU result, drives ALU operands and display)
// master : the surroundings (keypad scanner, ALU, display driver)
interface main_fsb_if;
  logic        kbEN;
  logic [3:0]  pressedkey;
  logic [15:0] ALUNum1;
  logic [15:0] ALUNum2;
  logic [3:0]  ALUOp;
  logic [15:0] ALUres;
  logic [15:0] Display;

  modport slave (
    input  kbEN, pressedkey, ALUres,
    output ALUNum1, ALUNum2, ALUOp, Display
  );

  modport master (
    output kbEN, pressedkey, ALUres,
    input  ALUNum1, ALUNum2, ALUOp, Display
  );
endinterface

// File: rtl/main_fsb.sv
// Control FSM of the 4-digit BCD keypad calculator.
// Assembles two BCD operands and an operator from key events, hands them to
// the external ALU, waits ALU_LAT clocks and captures the result for display.
// Key flow: kbEN rising edge is detected and registered together with the key
// code, so every key acts one clock after its event cycle.
module main_fsb #(
  parameter int ALU_LAT = 2  // clocks from ALU inputs driven to ALUres sampled (>= 1)
) (
  input  logic       clk,
  input  logic       rst,
  main_fsb_if.slave  bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  localparam logic [3:0] KEY_EQ = 4'hA;
  localparam logic [3:0] KEY_AC = 4'hB;
  localparam logic [3:0] OP_ADD = 4'hC;

  typedef enum logic [1:0] {
    S_NUM1   = 2'd0,
    S_NUM2   = 2'd1,
    S_CALC   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Key capture registers
  logic        r_kben_q;
  logic        r_evt;
  logic [3:0]  r_key;

  // FSM and datapath registers
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_num1, w_num1_next;
  logic [15:0] r_num2, w_num2_next;
  logic [3:0]  r_op, w_op_next;
  logic        r_got2, w_got2_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [15:0] r_alu_num1, w_alu_num1_next;
  logic [15:0] r_alu_num2, w_alu_num2_next;
  logic [3:0]  r_alu_op, w_alu_op_next;
  logic [15:0] r_display, w_display_next;

  // Decoded key classes of the registered event
  logic w_rise;
  logic w_digit;
  logic w_op;
  logic w_eq;
  logic w_ac;
  logic w_calc_done;

  assign w_rise      = bus.kbEN & ~r_kben_q;
  assign w_digit     = r_evt & (r_key <= 4'd9);
  assign w_op        = r_evt & (r_key >= OP_ADD);
  assign w_eq        = r_evt & (r_key == KEY_EQ);
  assign w_ac        = r_evt & (r_key == KEY_AC);
  assign w_calc_done = (r_state == S_CALC) && (r_cnt == CNT_LAST);

  // Append a digit unless the register already holds four significant digits
  function automatic logic [15:0] shift_in(input logic [15:0] v, input logic [3:0] d);
    return (v[15:12] != 4'd0) ? v : {v[11:0], d};
  endfunction

  // Rising-edge detection of kbEN; key code latched in the edge cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kben_q <= 1'b0;
      r_evt    <= 1'b0;
      r_key    <= 4'd0;
    end else begin
      r_kben_q <= bus.kbEN;
      r_evt    <= w_rise;
      if (w_rise) begin
        r_key <= bus.pressedkey;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NUM1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; AC overrides everything, other keys are dropped in CALC
  always_comb begin
    w_state_next = r_state;
    if (w_ac) begin
      w_state_next = S_NUM1;
    end else begin
      case (r_state)
        S_NUM1:   if (w_op) w_state_next = S_NUM2;
        S_NUM2:   if (w_eq && r_got2) w_state_next = S_CALC;
        S_CALC:   if (w_calc_done) w_state_next = S_RESULT;
        S_RESULT: begin
          if (w_digit) w_state_next = S_NUM1;
          else if (w_op) w_state_next = S_NUM2;
        end
        default:  w_state_next = S_NUM1;
      endcase
    end
  end

  // Output/datapath next values per state
  always_comb begin
    w_num1_next     = r_num1;
    w_num2_next     = r_num2;
    w_op_next       = r_op;
    w_got2_next     = r_got2;
    w_cnt_next      = r_cnt;
    w_alu_num1_next = r_alu_num1;
    w_alu_num2_next = r_alu_num2;
    w_alu_op_next   = r_alu_op;
    w_display_next  = r_display;
    if (w_ac) begin
      w_num1_next     = 16'd0;
      w_num2_next     = 16'd0;
      w_op_next       = OP_ADD;
      w_got2_next     = 1'b0;
      w_cnt_next      = '0;
      w_alu_num1_next = 16'd0;
      w_alu_num2_next = 16'd0;
      w_alu_op_next   = OP_ADD;
      w_display_next  = 16'd0;
    end else begin
      case (r_state)
        S_NUM1: begin
          if (w_digit) begin
            w_num1_next    = shift_in(r_num1, r_key);
            w_display_next = shift_in(r_num1, r_key);
          end else if (w_op) begin
            w_op_next = r_key;
          end
        end
        S_NUM2: begin
          if (w_digit) begin
            w_num2_next    = shift_in(r_num2, r_key);
            w_display_next = shift_in(r_num2, r_key);
            w_got2_next    = 1'b1;
          end else if (w_op && !r_got2) begin
            // operator may still be changed until operand 2 is started
            w_op_next = r_key;
          end else if (w_eq && r_got2) begin
            w_alu_num1_next = r_num1;
            w_alu_num2_next = r_num2;
            w_alu_op_next   = r_op;
            w_cnt_next      = '0;
          end
        end
        S_CALC: begin
          if (w_calc_done) begin
            // result becomes operand 1 so an operator key can chain on it
            w_display_next = bus.ALUres;
            w_num1_next    = bus.ALUres;
            w_num2_next    = 16'd0;
            w_got2_next    = 1'b0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_RESULT: begin
          if (w_digit) begin
            w_num1_next    = {12'd0, r_key};
            w_num2_next    = 16'd0;
            w_display_next = {12'd0, r_key};
          end else if (w_op) begin
            w_op_next = r_key;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num1     <= 16'd0;
      r_num2     <= 16'd0;
      r_op       <= OP_ADD;
      r_got2     <= 1'b0;
      r_cnt      <= '0;
      r_alu_num1 <= 16'd0;
      r_alu_num2 <= 16'd0;
      r_alu_op   <= OP_ADD;
      r_display  <= 16'd0;
    end else begin
      r_num1     <= w_num1_next;
      r_num2     <= w_num2_next;
      r_op       <= w_op_next;
      r_got2     <= w_got2_next;
      r_cnt      <= w_cnt_next;
      r_alu_num1 <= w_alu_num1_next;
      r_alu_num2 <= w_alu_num2_next;
      r_alu_op   <= w_alu_op_next;
      r_display  <= w_display_next;
    end
  end

  assign bus.ALUNum1 = r_alu_num1;
  assign bus.ALUNum2 = r_alu_num2;
  assign bus.ALUOp   = r_alu_op;
  assign bus.Display = r_display;

endmodule

// File: tb/tb_main_fsb.sv
// Bench for the calculator control FSM: keypad stimulus, a registered BCD ALU
// model, a decimal-arithmetic reference model feeding a scoreboard queue, and a
// monitor that pops and compares on every change of the DUT outputs.
module tb_main_fsb;
  localparam int ALU_LAT = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   rise_cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  main_fsb_if bus_if ();

  main_fsb #(.ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [15:0] disp;
    logic [15:0] n1;
    logic [15:0] n2;
    logic [3:0]  op;
    int          lat;
  } snap_t;

  snap_t sb_q[$];

  // reference model state: operands held as plain integers
  int         m_n1, m_n2;
  logic [3:0] m_op;
  bit         m_got2;
  int         m_phase;  // 0 entering first operand, 1 entering second, 2 showing result
  snap_t      m_cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int alu_dec(input int a, input int b, input logic [3:0] op);
    case (op)
      4'hC:    return (a + b) % 10000;
      4'hD:    return (a >= b) ? (a - b) : (a - b + 10000);
      4'hE:    return (a * b) % 10000;
      4'hF:    return (b == 0) ? 9999 : (a / b);
      default: return 0;
    endcase
  endfunction

  // registered ALU: result one clock after operands
  always @(posedge clk)
    bus_if.ALUres <= to_bcd(alu_dec(from_bcd(bus_if.ALUNum1), from_bcd(bus_if.ALUNum2), bus_if.ALUOp));

  function automatic bit same_out(input snap_t a, input snap_t b);
    return (a.disp == b.disp) && (a.n1 == b.n1) && (a.n2 == b.n2) && (a.op == b.op);
  endfunction

  task automatic push_exp(input snap_t s);
    if (!same_out(s, m_cur)) sb_q.push_back(s);
    m_cur = s;
  endtask

  task automatic model_clear();
    m_n1 = 0; m_n2 = 0; m_op = 4'hC; m_got2 = 0; m_phase = 0;
  endtask

  task automatic model_key(input logic [3:0] k);
    snap_t s;
    int    res;
    s = m_cur;
    s.lat = 2;
    if (k == 4'hB) begin
      model_clear();
      s.disp = 16'h0; s.n1 = 16'h0; s.n2 = 16'h0; s.op = 4'hC;
      push_exp(s);
    end else if (k <= 4'd9) begin
      if (m_phase == 0) begin
        if (m_n1 < 1000) m_n1 = m_n1 * 10 + int'(k);
        s.disp = to_bcd(m_n1);
      end else if (m_phase == 1) begin
        if (m_n2 < 1000) m_n2 = m_n2 * 10 + int'(k);
        m_got2 = 1;
        s.disp = to_bcd(m_n2);
      end else begin
        m_n1 = int'(k); m_n2 = 0; m_phase = 0;
        s.disp = to_bcd(m_n1);
      end
      push_exp(s);
    end else if (k >= 4'hC) begin
      if (m_phase != 1 || !m_got2) m_op = k;
      m_phase = 1;
    end else if (m_phase == 1 && m_got2) begin
      s.n1 = to_bcd(m_n1); s.n2 = to_bcd(m_n2); s.op = m_op;
      push_exp(s);
      res = alu_dec(m_n1, m_n2, m_op);
      m_n1 = res; m_n2 = 0; m_got2 = 0; m_phase = 2;
      s.disp = to_bcd(res);
      s.lat = 2 + ALU_LAT;
      push_exp(s);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    @(negedge clk);
    bus_if.kbEN = 1'b1;
    bus_if.pressedkey = k;
    rise_cyc = cyc;
    model_key(k);
    repeat (hold) @(negedge clk);
    bus_if.kbEN = 1'b0;
    bus_if.pressedkey = 4'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic press_seq(input logic [3:0] keys[], input int n);
    for (int i = 0; i < n; i++) press(keys[i], 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_disp"}, bus_if.Display, 16'h0000);
    chk({tag, "_num1"}, bus_if.ALUNum1, 16'h0000);
    chk({tag, "_num2"}, bus_if.ALUNum2, 16'h0000);
    chk({tag, "_op"}, {12'd0, bus_if.ALUOp}, 16'h000C);
  endtask

  task automatic resync_after_reset();
    sb_q.delete();
    model_clear();
    m_cur.disp = 16'h0; m_cur.n1 = 16'h0; m_cur.n2 = 16'h0; m_cur.op = 4'hC; m_cur.lat = 0;
  endtask

  initial begin
    logic [3:0] seq[];
    logic [51:0] mon_prev;
    logic [51:0] mon_now;
    snap_t e;
    int r;
    int hold;

    checks = 0; errors = 0; cyc = 0; rise_cyc = 0; mon_en = 0;
    rst = 1'b1;
    bus_if.kbEN = 1'b0;
    bus_if.pressedkey = 4'h0;
    resync_after_reset();
    mon_prev = {16'h0, 16'h0, 16'h0, 4'hC};

    // monitor: every change of the outputs must match the next expected snapshot
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          mon_now = {bus_if.Display, bus_if.ALUNum1, bus_if.ALUNum2, bus_if.ALUOp};
          if (mon_now !== mon_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_change actual=%h required=%h", mon_now, mon_prev);
            end else begin
              e = sb_q.pop_front();
              if (mon_now !== {e.disp, e.n1, e.n2, e.op}) begin
                errors++;
                $display("FAIL outputs actual disp=%h n1=%h n2=%h op=%h required disp=%h n1=%h n2=%h op=%h",
                         bus_if.Display, bus_if.ALUNum1, bus_if.ALUNum2, bus_if.ALUOp,
                         e.disp, e.n1, e.n2, e.op);
              end
              checks++;
              if (cyc - rise_cyc != e.lat) begin
                errors++;
                $display("FAIL latency actual=%0d required=%0d", cyc - rise_cyc, e.lat);
              end
            end
            mon_prev = mon_now;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1;

    // 1 + 1 =
    seq = '{4'h1, 4'hC, 4'h1, 4'hA};
    press_seq(seq, 4);
    chk("add_disp", bus_if.Display, 16'h0002);
    chk("add_num1", bus_if.ALUNum1, 16'h0001);
    chk("add_num2", bus_if.ALUNum2, 16'h0001);
    chk("add_op", {12'd0, bus_if.ALUOp}, 16'h000C);
    // chain on result: * 3 =
    seq = '{4'hE, 4'h3, 4'hA};
    press_seq(seq, 3);
    chk("chain_num1", bus_if.ALUNum1, 16'h0002);
    chk("chain_disp", bus_if.Display, 16'h0006);
    press(4'hB, 1);
    chk("ac_disp", bus_if.Display, 16'h0000);

    // 1 - 1 =
    seq = '{4'h1, 4'hD, 4'h1, 4'hA};
    press_seq(seq, 4);
    chk("sub_op", {12'd0, bus_if.ALUOp}, 16'h000D);
    chk("sub_disp", bus_if.Display, 16'h0000);
    press(4'hB, 1);

    // 1 2 + 1 =
    seq = '{4'h1, 4'h2, 4'hC, 4'h1, 4'hA};
    press_seq(seq, 5);
    chk("add12_disp", bus_if.Display, 16'h0013);
    chk("add12_num1", bus_if.ALUNum1, 16'h0012);
    press(4'hB, 1);

    // 1 2 / 2 =
    seq = '{4'h1, 4'h2, 4'hF, 4'h2, 4'hA};
    press_seq(seq, 5);
    chk("div_op", {12'd0, bus_if.ALUOp}, 16'h000F);
    chk("div_disp", bus_if.Display, 16'h0006);
    press(4'hB, 1);

    // held key counts once
    press(4'h5, 10);
    chk("held_disp", bus_if.Display, 16'h0005);
    press(4'hB, 1);

    // fifth digit ignored
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    press_seq(seq, 5);
    chk("five_disp", bus_if.Display, 16'h1234);
    press(4'hB, 1);

    // randomized key stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      hold = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(1, 3);
      if (r < 50)      press(4'($urandom_range(0, 9)), hold);
      else if (r < 70) press(4'(12 + $urandom_range(0, 3)), hold);
      else if (r < 92) press(4'hA, hold);
      else             press(4'hB, hold);
    end

    repeat (10) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expected actual=%0d required=0", sb_q.size());
    end

    // reset while the ALU is being waited on
    press(4'hB, 1);
    seq = '{4'h1, 4'h2, 4'hC, 4'h3};
    press_seq(seq, 4);
    @(negedge clk);
    bus_if.kbEN = 1'b1;
    bus_if.pressedkey = 4'hA;
    rise_cyc = cyc;
    model_key(4'hA);
    @(negedge clk);
    bus_if.kbEN = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("calc_rst");
    rst = 1'b0;
    resync_after_reset();
    repeat (6) @(negedge clk);
    chk("post_rst_disp", bus_if.Display, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
